// File: rtl/cnt_ce_gate.sv
// Counting-window enable generator for the cbnce event counter: synchronises EVT_IN,
// detects rising edges and emits one-cycle CE pulses only while the window is open.
module cnt_ce_gate #(
  parameter int unsigned TMR         = 0,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned GATE_W      = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EVT_IN,
  input  logic              START,
  input  logic              STOP,
  input  logic              CLEAR,
  input  logic [GATE_W-1:0] GATE_LEN,
  output logic              CE,
  output logic              CNT_RST,
  output logic              BUSY,
  output logic              DONE,
  output logic [1:0]        STATE
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CLR  = 2'b01,
    S_RUN  = 2'b10,
    S_DONE = 2'b11
  } state_t;

  // Everything except the FSM state that is protected by triplication.
  typedef struct packed {
    logic [GATE_W-1:0] gcnt;
    logic              glim;
    logic              ce;
    logic              cnt_rst;
    logic              busy;
    logic              done;
  } aux_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   edge_q;

  logic [1:0] state_raw;
  state_t     state_v;
  state_t     state_n;
  aux_t       aux_v;
  aux_t       aux_n;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], EVT_IN};
      prev_q <= sync_q[SYNC_STAGES-1];
      edge_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
    end
  end

  assign state_v = state_t'(state_raw);

  always_comb begin
    state_n         = state_v;
    aux_n           = aux_v;
    aux_n.cnt_rst   = 1'b0;
    aux_n.ce        = edge_q & (state_v == S_RUN) & ~STOP & ~CLEAR;
    if (CLEAR) begin
      state_n       = S_IDLE;
      aux_n.cnt_rst = 1'b1;
    end else begin
      case (state_v)
        S_IDLE, S_DONE: begin
          if (START) begin
            state_n       = S_CLR;
            aux_n.cnt_rst = 1'b1;
          end
        end
        S_CLR: begin
          // glim remembers whether the sampled length was non-zero (0 = run until STOP)
          state_n    = S_RUN;
          aux_n.gcnt = GATE_LEN;
          aux_n.glim = |GATE_LEN;
        end
        S_RUN: begin
          if (STOP) begin
            state_n = S_DONE;
          end else if (aux_v.glim) begin
            if (aux_v.gcnt == GATE_W'(1)) state_n = S_DONE;
            aux_n.gcnt = aux_v.gcnt - 1'b1;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
    aux_n.busy = (state_n == S_CLR) || (state_n == S_RUN);
    aux_n.done = (state_n == S_DONE);
  end

  generate
    if (TMR != 0) begin : g_tmr
      logic [1:0] state_a, state_b, state_c;
      aux_t       aux_a, aux_b, aux_c;

      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          state_a <= S_IDLE;
          state_b <= S_IDLE;
          state_c <= S_IDLE;
          aux_a   <= '0;
          aux_b   <= '0;
          aux_c   <= '0;
        end else begin
          state_a <= state_n;
          state_b <= state_n;
          state_c <= state_n;
          aux_a   <= aux_n;
          aux_b   <= aux_n;
          aux_c   <= aux_n;
        end
      end

      // Bitwise majority: a single corrupted copy is outvoted and rewritten next cycle.
      assign state_raw = (state_a & state_b) | (state_a & state_c) | (state_b & state_c);
      assign aux_v     = (aux_a & aux_b) | (aux_a & aux_c) | (aux_b & aux_c);
    end else begin : g_simplex
      logic [1:0] state_q;
      aux_t       aux_q;

      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          state_q <= S_IDLE;
          aux_q   <= '0;
        end else begin
          state_q <= state_n;
          aux_q   <= aux_n;
        end
      end

      assign state_raw = state_q;
      assign aux_v     = aux_q;
    end
  endgenerate

  assign CE      = aux_v.ce;
  assign CNT_RST = aux_v.cnt_rst;
  assign BUSY    = aux_v.busy;
  assign DONE    = aux_v.done;
  assign STATE   = state_raw;

endmodule

// File: tb/tb_cnt_ce_gate.sv
// Bench for cnt_ce_gate: simplex and TMR instances share stimulus and are compared
// every cycle against a window/edge model, plus hand-computed scenario totals.
module tb_cnt_ce_gate;
  localparam int unsigned SYNC = 2;
  localparam int unsigned GW   = 16;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          EVT_IN = 1'b0;
  logic          START = 1'b0;
  logic          STOP = 1'b0;
  logic          CLEAR = 1'b0;
  logic [GW-1:0] GATE_LEN = '0;

  logic       ce0, crst0, busy0, done0;
  logic [1:0] st0;
  logic       ce1, crst1, busy1, done1;
  logic [1:0] st1;

  always #5 CLK = ~CLK;

  cnt_ce_gate #(.TMR(0), .SYNC_STAGES(SYNC), .GATE_W(GW)) dut0 (
    .CLK(CLK), .RST(RST), .EVT_IN(EVT_IN), .START(START), .STOP(STOP), .CLEAR(CLEAR),
    .GATE_LEN(GATE_LEN), .CE(ce0), .CNT_RST(crst0), .BUSY(busy0), .DONE(done0), .STATE(st0)
  );

  cnt_ce_gate #(.TMR(1), .SYNC_STAGES(SYNC), .GATE_W(GW)) dut_t (
    .CLK(CLK), .RST(RST), .EVT_IN(EVT_IN), .START(START), .STOP(STOP), .CLEAR(CLEAR),
    .GATE_LEN(GATE_LEN), .CE(ce1), .CNT_RST(crst1), .BUSY(busy1), .DONE(done1), .STATE(st1)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: window mode 0=idle 1=clr 2=run 3=done, remaining run cycles, event history.
  int       m_state = 0;
  int       m_left  = 0;
  bit       m_lim   = 1'b0;
  bit       m_ce    = 1'b0;
  bit       m_rst   = 1'b0;
  int       m_q     = 0;
  bit [15:0] hist   = '0;
  bit       m_edge;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_state = 0; m_left = 0; m_lim = 1'b0; m_ce = 1'b0; m_rst = 1'b0; m_q = 0; hist = '0;
    end else begin
      // hist[d] is EVT_IN as sampled d+1 edges ago; edge seen by the window SYNC+1 edges late
      m_edge = hist[SYNC] & ~hist[SYNC+1];
      m_ce   = m_edge && (m_state == 2) && !STOP && !CLEAR;
      m_rst  = 1'b0;
      if (CLEAR) begin
        m_state = 0;
        m_rst   = 1'b1;
      end else if ((m_state == 0 || m_state == 3) && START) begin
        m_state = 1;
        m_rst   = 1'b1;
      end else if (m_state == 1) begin
        m_state = 2;
        m_lim   = (GATE_LEN != 0);
        m_left  = int'(GATE_LEN);
      end else if (m_state == 2) begin
        if (STOP) m_state = 3;
        else if (m_lim) begin
          m_left = m_left - 1;
          if (m_left == 0) m_state = 3;
        end
      end
      if (m_rst) m_q = 0;
      else if (m_ce) m_q = m_q + 1;
      hist = {hist[14:0], EVT_IN};
    end
  end

  logic [5:0] expv;
  int ce_cnt0 = 0, rst_cnt0 = 0, run_cyc0 = 0, q0 = 0, ce_cnt1 = 0;
  logic [1:0] prev_st0 = 2'b00;
  logic       ce_done_entry = 1'b0;

  always @(negedge CLK) begin
    expv = {2'(m_state), (m_state == 1 || m_state == 2), (m_state == 3), m_rst, m_ce};
    chk("cycle_simplex", {st0, busy0, done0, crst0, ce0}, expv);
    chk("cycle_tmr", {st1, busy1, done1, crst1, ce1}, expv);
    if (crst0) q0 = 0;
    else if (ce0) q0 = q0 + 1;
    ce_cnt0  = ce_cnt0 + int'(ce0);
    ce_cnt1  = ce_cnt1 + int'(ce1);
    rst_cnt0 = rst_cnt0 + int'(crst0);
    run_cyc0 = run_cyc0 + int'(st0 == 2'b10);
    if (st0 == 2'b11 && prev_st0 == 2'b10) ce_done_entry = ce0;
    prev_st0 = st0;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic pulse_start();
    START = 1'b1; cyc(1); START = 1'b0;
  endtask

  task automatic pulse_stop();
    STOP = 1'b1; cyc(1); STOP = 1'b0;
  endtask

  task automatic evt_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      EVT_IN = 1'b1; cyc(4);
      EVT_IN = 1'b0; cyc(4);
    end
  endtask

  initial begin
    int b_ce, b_rst, b_run, b_ce1, lat;

    // Reset held with EVT_IN toggling
    for (int i = 0; i < 6; i++) begin
      EVT_IN = (i % 2 == 1);
      cyc(1);
    end
    chk("reset_outs_simplex", {st0, busy0, done0, crst0, ce0}, 0);
    chk("reset_outs_tmr", {st1, busy1, done1, crst1, ce1}, 0);
    EVT_IN = 1'b1;
    RST    = 1'b0;
    cyc(6);
    chk("release_edge_ignored_ce", ce_cnt0, 0);
    chk("release_edge_state", st0, 0);
    EVT_IN = 1'b0;
    cyc(4);

    // Unlimited window, 5 pulses, STOP
    GATE_LEN = '0;
    b_ce = ce_cnt0; b_rst = rst_cnt0;
    pulse_start();
    cyc(2);
    EVT_IN = 1'b1;
    lat = 0;
    for (int k = 1; k <= 4; k++) begin
      cyc(1);
      if (ce0 && lat == 0) lat = k;
    end
    EVT_IN = 1'b0;
    cyc(4);
    evt_pulses(4);
    cyc(6);
    pulse_stop();
    cyc(2);
    chk("latency_cycles", lat, SYNC + 2);
    chk("s2_ce_count", ce_cnt0 - b_ce, 5);
    chk("s2_cnt_rst_count", rst_cnt0 - b_rst, 1);
    chk("s2_state", st0, 3);
    chk("s2_counter_q", q0, 5);
    chk("s2_model_q", m_q, 5);

    // Fixed gate of 10, rising EVT_IN every 3 cycles aligned to RUN cycles 0,3,6,9
    GATE_LEN = 16'd10;
    b_ce = ce_cnt0; b_rst = rst_cnt0; b_run = run_cyc0;
    for (int c = 0; c < 25; c++) begin
      EVT_IN = (c % 3 == 0) && (c <= 9);
      START  = (c == 1);
      cyc(1);
    end
    START = 1'b0; EVT_IN = 1'b0;
    chk("s3_run_cycles", run_cyc0 - b_run, 10);
    chk("s3_ce_count", ce_cnt0 - b_ce, 4);
    chk("s3_cnt_rst_count", rst_cnt0 - b_rst, 1);
    chk("s3_ce_first_done", ce_done_entry, 1);
    chk("s3_state", st0, 3);
    chk("s3_model_q", m_q, 4);

    // CLEAR and STOP together in RUN, coinciding with a detected edge
    GATE_LEN = '0;
    b_ce = ce_cnt0; b_rst = rst_cnt0;
    for (int c = 0; c < 6; c++) begin
      EVT_IN = (c >= 2);
      START  = (c == 1);
      STOP   = (c == 5);
      CLEAR  = (c == 5);
      cyc(1);
    end
    START = 1'b0; STOP = 1'b0; CLEAR = 1'b0;
    chk("s4_cnt_rst_after_clear", crst0, 1);
    chk("s4_state_idle", st0, 0);
    chk("s4_no_ce", ce0, 0);
    cyc(3);
    EVT_IN = 1'b0;
    cyc(3);
    chk("s4_ce_count", ce_cnt0 - b_ce, 0);
    chk("s4_cnt_rst_count", rst_cnt0 - b_rst, 2);
    chk("s4_counter_q", q0, 0);
    pulse_stop();
    cyc(2);
    chk("stop_in_idle_ignored", st0, 0);

    // START in RUN ignored; START from DONE restarts and clears the counter
    b_rst = rst_cnt0;
    pulse_start();
    cyc(2);
    evt_pulses(2);
    cyc(6);
    pulse_start();
    cyc(2);
    chk("s5_start_in_run_no_rst", rst_cnt0 - b_rst, 1);
    chk("s5_still_run", st0, 2);
    pulse_stop();
    cyc(2);
    chk("s5_done_state", st0, 3);
    chk("s5_counter_q", q0, 2);
    pulse_start();
    cyc(2);
    chk("s5_restart_q_cleared", q0, 0);
    chk("s5_restart_run", st0, 2);
    chk("s5_restart_rst_count", rst_cnt0 - b_rst, 2);
    pulse_stop();
    cyc(2);

    // Shortest limited window
    GATE_LEN = 16'd1;
    b_run = run_cyc0;
    pulse_start();
    cyc(4);
    chk("gate1_run_cycles", run_cyc0 - b_run, 1);
    chk("gate1_state", st0, 3);

    // Upset one TMR state copy to DONE while counting an unlimited window
    GATE_LEN = '0;
    b_ce = ce_cnt0; b_ce1 = ce_cnt1;
    pulse_start();
    cyc(3);
    force dut_t.g_tmr.state_c = 2'b11;
    evt_pulses(5);
    release dut_t.g_tmr.state_c;
    cyc(6);
    pulse_stop();
    cyc(2);
    chk("s6_tmr_ce_count", ce_cnt1 - b_ce1, 5);
    chk("s6_simplex_ce_count", ce_cnt0 - b_ce, 5);
    chk("s6_tmr_state", st1, 3);

    // Asynchronous reset in the middle of a window
    pulse_start();
    cyc(3);
    EVT_IN = 1'b1;
    cyc(2);
    RST = 1'b1;
    #1;
    chk("midrst_outs_simplex", {st0, busy0, done0, crst0, ce0}, 0);
    chk("midrst_outs_tmr", {st1, busy1, done1, crst1, ce1}, 0);
    cyc(2);
    RST = 1'b0;
    EVT_IN = 1'b0;
    cyc(4);
    chk("midrst_idle", st0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
